// File: rtl/clk_divider_prog.sv
// Runtime-programmable clock divider: square-wave clk_d plus a one-cycle tick
// at the start of each period. New ratios take effect only at period boundaries or on clr.
module clk_divider_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] div_ratio,
    output logic             clk_d,
    output logic             tick,
    output logic [WIDTH-1:0] ratio_active
);

    // Ratios 0 and 1 cannot form a high and a low phase, so they run as 2.
    function automatic logic [WIDTH-1:0] sanitize(input logic [WIDTH-1:0] r);
        return (r < WIDTH'(2)) ? WIDTH'(2) : r;
    endfunction

    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
    localparam logic [WIDTH-1:0] DEFAULT_SAN = sanitize(WIDTH'(DEFAULT_DIV));

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_ratio_q;
    logic             r_clk_d;
    logic             r_tick;

    logic             w_terminal;
    logic [WIDTH-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_ratio_next;
    logic             w_clk_d_next;
    logic             w_tick_next;

    // Next count/ratio for an enabled cycle; r_ratio_q >= 2 so the subtraction never wraps.
    always_comb begin
        w_terminal   = (r_cnt >= (r_ratio_q - ONE));
        w_cnt_next   = r_cnt;
        w_ratio_next = r_ratio_q;
        w_tick_next  = 1'b0;
        if (w_terminal) begin
            w_cnt_next   = '0;
            w_ratio_next = sanitize(div_ratio);
            w_tick_next  = 1'b1;
        end else begin
            w_cnt_next   = r_cnt + ONE;
            w_ratio_next = r_ratio_q;
            w_tick_next  = 1'b0;
        end
        w_clk_d_next = (w_cnt_next >= (w_ratio_next >> 1));
    end

    // State registers; rst beats clr, clr beats en, otherwise hold with tick cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_ratio_q <= DEFAULT_SAN;
            r_clk_d   <= 1'b0;
            r_tick    <= 1'b0;
        end else if (clr) begin
            r_cnt     <= '0;
            r_ratio_q <= sanitize(div_ratio);
            r_clk_d   <= 1'b0;
            r_tick    <= 1'b0;
        end else if (en) begin
            r_cnt     <= w_cnt_next;
            r_ratio_q <= w_ratio_next;
            r_clk_d   <= w_clk_d_next;
            r_tick    <= w_tick_next;
        end else begin
            r_cnt     <= r_cnt;
            r_ratio_q <= r_ratio_q;
            r_clk_d   <= r_clk_d;
            r_tick    <= 1'b0;
        end
    end

    assign clk_d        = r_clk_d;
    assign tick         = r_tick;
    assign ratio_active = r_ratio_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Self-checking bench for clk_divider_prog: directed steps then random traffic,
// checked each cycle against a period-waveform reference model.
module tb_clk_divider_prog;

    localparam int WIDTH = 8;
    localparam int DEF   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en  = 1'b0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] div_ratio = 8'd4;
    logic             clk_d;
    logic             tick;
    logic [WIDTH-1:0] ratio_active;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: the current period is a list of clk_d values, low floor(N/2) then high ceil(N/2).
    int unsigned m_ratio;
    bit          m_wave[$];
    bit          e_clk;
    bit          e_tick;

    clk_divider_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .clr          (clr),
        .div_ratio    (div_ratio),
        .clk_d        (clk_d),
        .tick         (tick),
        .ratio_active (ratio_active)
    );

    always #5 clk = ~clk;

    function automatic int unsigned san(input int unsigned r);
        return (r < 2) ? 2 : r;
    endfunction

    task automatic start_period(input int unsigned n, input bit with_tick);
        m_ratio = n;
        m_wave.delete();
        for (int i = 0; i < int'(n); i++) m_wave.push_back(i >= int'(n / 2));
        e_clk  = m_wave.pop_front();
        e_tick = with_tick;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int unsigned exp);
        n_tests++;
        assert (obs === 32'(exp)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, compare all outputs just after the edge.
    task automatic cycle(input bit r, input bit c, input bit e, input int unsigned d);
        rst       = r;
        clr       = c;
        en        = e;
        div_ratio = d[WIDTH-1:0];
        @(posedge clk);
        if (r) begin
            start_period(san(DEF), 1'b0);
        end else if (c) begin
            start_period(san(d), 1'b0);
        end else if (e) begin
            if (m_wave.size() == 0) begin
                start_period(san(d), 1'b1);
            end else begin
                e_clk  = m_wave.pop_front();
                e_tick = 1'b0;
            end
        end else begin
            e_tick = 1'b0;
        end
        #1;
        chk("clk_d", {31'd0, clk_d}, e_clk);
        chk("tick", {31'd0, tick}, e_tick);
        chk("ratio_active", {24'd0, ratio_active}, m_ratio);
    endtask

    task automatic run(input int n, input int unsigned d);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, d);
    endtask

    initial begin
        int unsigned d;
        bit r, c, e;

        // Reset (en high is overridden), then default ratio 4: clk_d 0,0,1,1.
        cycle(1'b1, 1'b0, 1'b1, 4);
        cycle(1'b1, 1'b1, 1'b1, 9);
        chk("reset_ratio", {24'd0, ratio_active}, 4);
        chk("reset_clk_d", {31'd0, clk_d}, 0);
        run(16, 4);

        // N=5, then sanitised 0 and 1.
        cycle(1'b0, 1'b1, 1'b0, 5);
        run(15, 5);
        cycle(1'b0, 1'b1, 1'b1, 0);
        chk("ratio0_sanitised", {24'd0, ratio_active}, 2);
        run(6, 0);
        run(6, 1);

        // Ratio 4 -> 7 requested at cnt=1: only loaded on the wrap.
        cycle(1'b0, 1'b1, 1'b1, 4);
        cycle(1'b0, 1'b0, 1'b1, 4);
        run(2, 7);
        chk("ratio_held_midperiod", {24'd0, ratio_active}, 4);
        run(1, 7);
        chk("ratio_loaded_on_wrap", {24'd0, ratio_active}, 7);
        run(20, 7);

        // N=6 with en low for 3 cycles at cnt=2.
        cycle(1'b0, 1'b1, 1'b1, 6);
        run(2, 6);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 6);
        run(16, 6);

        // clr mid-period with 10, then rst and clr together.
        run(3, 6);
        cycle(1'b0, 1'b1, 1'b0, 10);
        chk("clr_ratio", {24'd0, ratio_active}, 10);
        chk("clr_clk_d", {31'd0, clk_d}, 0);
        run(7, 10);
        cycle(1'b1, 1'b1, 1'b1, 10);
        chk("rst_over_clr", {24'd0, ratio_active}, DEF);

        // Maximum ratio 255: 255-cycle period, low 127 / high 128.
        cycle(1'b0, 1'b1, 1'b1, 255);
        run(520, 255);

        // Random traffic.
        d = 4;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 11) == 0)
                d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            cycle(r, c, e, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
